add_serial_issue: RTL and testbench

- Upstream issue/collect stage for the 8-bit serial adder (add_serial).
- Buffers operand pairs from a valid/ready producer and launches one addition at a time by pulsing the adder's en with stable a/b.
- Waits a fixed LAT cycles, captures the adder's out and presents it on a valid/ready result port.
- Isolates the rest of the design from the adder's multi-cycle, handshake-free timing.

---
 rtl/add_serial_pkg.sv | 30 +++
 rtl/add_serial_opfifo.sv | 54 +++++
 rtl/add_serial_issue.sv | 136 +++++++++++++
 tb/tb_add_serial_issue.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_serial_pkg.sv
// Shared definitions for the add_serial issue/collect stage.
//   issue_state_t : issue FSM state encoding
//   ADD_*         : default width, FIFO depth and launch-to-capture latency
//   clog2         : ceiling log2, used to size pointers and occupancy counts
package add_serial_pkg;

  localparam int unsigned ADD_WIDTH = 8;
  localparam int unsigned ADD_DEPTH = 4;
  localparam int unsigned ADD_LAT   = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } issue_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_serial_opfifo.sv
// Operand-pair FIFO for the add_serial issue stage.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push     : write i_wdata (caller guarantees not full)
//   i_pop      : drop the head entry (caller guarantees not empty)
//   o_head     : oldest entry, valid whenever o_count > 0
//   o_count    : current occupancy, 0..DEPTH
module add_serial_opfifo
  import add_serial_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [DW-1:0]           i_wdata,
  input  logic                    i_pop,
  output logic [DW-1:0]           o_head,
  output logic [clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [DW-1:0]  r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/add_serial_issue.sv
// Issue/collect stage wrapping the multi-cycle serial adder.
// Operand pairs are buffered in a FIFO, launched one at a time with a
// single-cycle add_en and stable add_a/add_b, and the adder output is
// captured a fixed LAT cycles after the launch cycle and offered on a
// valid/ready result port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_ready = (fifo_count < DEPTH)
//   in_a, in_b          : operands
//   add_en, add_a/add_b : adder launch pulse and held operands
//   add_out             : adder result
//   res_valid/res_ready : result handshake; res_data = captured sum
//   busy                : FSM not idle
//   fifo_count          : FIFO occupancy
module add_serial_issue
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH,
  parameter int unsigned DEPTH = ADD_DEPTH,
  parameter int unsigned LAT   = ADD_LAT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   add_en,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic                   busy,
  output logic [clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned CW   = clog2(DEPTH) + 1;
  // LAT is at most 255, so the wait counter never needs more than 8 bits.
  localparam logic [7:0]  LAST = 8'(LAT - 1);

  issue_state_t        r_state;
  issue_state_t        w_state_nxt;
  logic [7:0]          r_cnt;
  logic [WIDTH-1:0]    r_add_a;
  logic [WIDTH-1:0]    r_add_b;
  logic                r_res_valid;
  logic [WIDTH-1:0]    r_res_data;
  logic                w_push;
  logic                w_launch;
  logic [2*WIDTH-1:0]  w_head;
  logic [CW-1:0]       w_count;

  assign in_ready = (w_count < CW'(DEPTH));
  assign w_push   = in_valid && in_ready;

  add_serial_opfifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({in_a, in_b}),
    .i_pop   (w_launch),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // w_launch marks the edge entering LAUNCH: it pops the FIFO and loads
  // the adder operands in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_count != '0) begin
          w_state_nxt = LAUNCH;
          w_launch    = 1'b1;
        end
      end
      LAUNCH: w_state_nxt = WAIT;
      WAIT: begin
        if (r_cnt == LAST) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (r_res_valid && res_ready) begin
          if (w_count != '0) begin
            w_state_nxt = LAUNCH;
            w_launch    = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_launch) {r_add_a, r_add_b} <= w_head;

      case (r_state)
        LAUNCH:  r_cnt <= '0;
        WAIT:    r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      if (r_state == WAIT && r_cnt == LAST) begin
        r_res_data  <= add_out;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign add_en     = (r_state == LAUNCH);
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign busy       = (r_state != IDLE);
  assign fifo_count = w_count;

endmodule

// File: tb/tb_add_serial_issue.sv
module tb_add_serial_issue;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned L = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         add_en;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_out;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         busy;
  logic [2:0]   fifo_count;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned tcyc   = 0;

  always #5 clk = ~clk;

  add_serial_issue #(
    .WIDTH (W),
    .DEPTH (D),
    .LAT   (L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_en     (add_en),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_out    (add_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Serial adder stand-in: the sum appears 8 cycles after en is sampled,
  // with junk on out before that, so an early capture is visible.
  logic [W-1:0] m_sum;
  logic [3:0]   m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= '0;
      m_sum   <= '0;
      add_out <= '0;
    end else if (add_en) begin
      m_cnt   <= 4'd1;
      m_sum   <= add_a + add_b;
      add_out <= 8'($urandom);
    end else if (m_cnt != 4'd0) begin
      if (m_cnt == 4'd8) begin
        add_out <= m_sum;
        m_cnt   <= '0;
      end else begin
        m_cnt <= m_cnt + 4'd1;
      end
    end
  end

  // Reference model: a queue of accepted operand pairs; every launch must
  // take the oldest pair, and each result must equal that pair's sum mod 256.
  logic [15:0]  opq[$];
  logic [15:0]  op;
  bit           pending = 1'b0;
  logic [W-1:0] infl_sum;
  int unsigned  mcyc = 0, launch_cyc = 0, en_pulses = 0;
  bit           m_push, m_acc, m_rv, m_en;
  logic [15:0]  m_op;
  logic [W-1:0] m_rd, m_a, m_b;

  always @(posedge clk) begin
    m_push = rst_n && in_valid && in_ready;
    m_op   = {in_a, in_b};
    m_acc  = res_valid && res_ready;
    m_rv   = res_valid;
    m_en   = add_en;
    m_rd   = res_data;
    m_a    = add_a;
    m_b    = add_b;
    #1;
    mcyc++;
    if (!rst_n) begin
      opq.delete();
      pending = 1'b0;
    end else begin
      if (m_acc) pending = 1'b0;
      if (add_en) begin
        en_pulses++;
        chk("en_single_cycle", 32'(m_en), 32'(0));
        chk("launch_while_pending", 32'(pending), 32'(0));
        chk("launch_nonempty", 32'(opq.size() != 0), 32'(1));
        if (opq.size() != 0) begin
          op = opq.pop_front();
          chk("add_a_launch", 32'(add_a), 32'(op[15:8]));
          chk("add_b_launch", 32'(add_b), 32'(op[7:0]));
          infl_sum   = 8'(op[15:8] + op[7:0]);
          pending    = 1'b1;
          launch_cyc = mcyc;
        end
      end else begin
        chk("add_a_stable", 32'(add_a), 32'(m_a));
        chk("add_b_stable", 32'(add_b), 32'(m_b));
      end
      if (m_push) opq.push_back(m_op);
      chk("fifo_count", 32'(fifo_count), 32'(opq.size()));
      chk("in_ready", 32'(in_ready), 32'(opq.size() < D));
      if (res_valid && !m_rv) begin
        chk("res_for_pending", 32'(pending), 32'(1));
        chk("res_data_model", 32'(res_data), 32'(infl_sum));
        chk("res_latency", mcyc - launch_cyc, L + 1);
      end
      if (m_rv && !m_acc) begin
        chk("res_valid_hold", 32'(res_valid), 32'(1));
        chk("res_data_hold", 32'(res_data), 32'(m_rd));
      end
    end
  end

  task automatic tick();
    bit p;
    p = in_valid && in_ready;
    @(posedge clk);
    #2;
    if (p) in_valid = 1'b0;
    tcyc++;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
  endtask

  // Single op into an idle, empty block with res_ready high: push at E0,
  // add_en after E1, result after E(L+2) for exactly one cycle.
  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b);
    drive(a, b);
    tick();
    chk("single_busy_e0", 32'(busy), 32'(0));
    chk("single_count_e0", 32'(fifo_count), 32'(1));
    tick();
    chk("single_en_e1", 32'(add_en), 32'(1));
    chk("single_busy_e1", 32'(busy), 32'(1));
    chk("single_add_a", 32'(add_a), 32'(a));
    chk("single_add_b", 32'(add_b), 32'(b));
    tick();
    chk("single_en_e2", 32'(add_en), 32'(0));
    repeat (L - 1) tick();
    chk("single_valid_early", 32'(res_valid), 32'(0));
    tick();
    chk("single_valid", 32'(res_valid), 32'(1));
    chk("single_data", 32'(res_data), 32'(8'(a + b)));
    tick();
    chk("single_valid_drop", 32'(res_valid), 32'(0));
    chk("single_idle", 32'(busy), 32'(0));
  endtask

  task automatic get_result(input string tag, input logic [W-1:0] exp, output int unsigned at);
    int unsigned n;
    n = 0;
    while (!(res_valid && res_ready) && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 60), 32'(1));
    chk(tag, 32'(res_data), 32'(exp));
    at = tcyc;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pa[6];
    logic [W-1:0] pb[6];
    logic [W-1:0] first;
    int unsigned  at[6];
    int unsigned  e0, n;
    bit           ok;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_add_en", 32'(add_en), 32'(0));
    chk("rst_add_a", 32'(add_a), 32'(0));
    chk("rst_add_b", 32'(add_b), 32'(0));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_res_data", 32'(res_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    rst_n = 1'b1;
    tick();

    // Directed single ops, including carry-out wrap cases.
    run_single(8'h3C, 8'h05);
    run_single(8'hFF, 8'h01);
    run_single(8'h80, 8'h80);
    run_single(8'h7F, 8'h01);
    for (int i = 0; i < 4; i++) run_single(8'($urandom), 8'($urandom));

    // Back-to-back with res_ready high.
    e0 = en_pulses;
    drive(8'h01, 8'h02); tick();
    drive(8'h10, 8'h20); tick();
    chk("pushpop_count", 32'(fifo_count), 32'(1));
    drive(8'hAA, 8'h55); tick();
    get_result("b2b_0", 8'h03, at[0]);
    get_result("b2b_1", 8'h30, at[1]);
    get_result("b2b_2", 8'hFF, at[2]);
    chk("b2b_gap_1", at[1] - at[0], L + 2);
    chk("b2b_gap_2", at[2] - at[1], L + 2);
    repeat (3) tick();
    chk("b2b_en_pulses", en_pulses - e0, 3);

    // Backpressure: 6 pairs offered with res_ready low; 5 fit.
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    for (int i = 0; i < 5; i++) begin
      drive(pa[i], pb[i]);
      chk("bp_ready_before_push", 32'(in_ready), 32'(1));
      tick();
    end
    drive(pa[5], pb[5]);
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'(0));
    chk("bp_full_count", 32'(fifo_count), 32'(D));
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_first_timeout", 32'(n < 40), 32'(1));
    first = res_data;
    chk("bp_first_data", 32'(first), 32'(8'(pa[0] + pb[0])));
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (!(res_valid === 1'b1 && res_data === first && in_ready === 1'b0)) ok = 1'b0;
    end
    chk("bp_hold_20", 32'(ok), 32'(1));
    res_ready = 1'b1;
    get_result("bp_res_0", 8'(pa[0] + pb[0]), at[0]);
    chk("bp_pop_count", 32'(fifo_count), 32'(D - 1));
    tick();
    chk("bp_refill_count", 32'(fifo_count), 32'(D));
    chk("bp_refill_ready", 32'(in_ready), 32'(0));
    for (int i = 1; i < 6; i++) begin
      get_result("bp_res", 8'(pa[i] + pb[i]), at[i]);
      chk("bp_gap", at[i] - at[i-1], L + 2);
    end
    repeat (3) tick();

    // Reset while the counter sits at 5 with two pairs queued.
    drive(8'h11, 8'h22); tick();
    drive(8'h33, 8'h44); tick();
    drive(8'h55, 8'h66); tick();
    chk("rmid_queued", 32'(fifo_count), 32'(2));
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("rmid_res_valid", 32'(res_valid), 32'(0));
    chk("rmid_add_en", 32'(add_en), 32'(0));
    chk("rmid_count", 32'(fifo_count), 32'(0));
    chk("rmid_busy", 32'(busy), 32'(0));
    chk("rmid_ready", 32'(in_ready), 32'(1));
    tick();
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (30) begin
      tick();
      if (res_valid !== 1'b0 || add_en !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("rmid_quiet", 32'(ok), 32'(1));
    run_single(8'($urandom), 8'($urandom));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
